ssd_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for an N-digit common-anode 7-segment display.

---
 rtl/ssd_scan_ctrl.sv | 109 ++++++++++
 tb/tb_ssd_scan_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_ctrl.sv
// Scan controller for an N-digit common-anode 7-segment display: rotates the
// active-low anode one-hot and presents the selected BCD digit, double-buffered per frame.
module ssd_scan_ctrl #(
   parameter int N_DIG       = 8,
   parameter int REFRESH_DIV = 100000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [4*N_DIG-1:0]   digits_in,
   input  logic                 load,
   input  logic [N_DIG-1:0]     digit_en,
   input  logic                 lzb_en,
   output logic [3:0]           bcd,
   output logic [N_DIG-1:0]     AN,
   output logic                 pending,
   output logic                 frame_start
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam int IW = $clog2(N_DIG);
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(N_DIG - 1);

   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [4*N_DIG-1:0]   active_q, active_d;
   logic [4*N_DIG-1:0]   pend_buf_q, pend_buf_d;
   logic                 pending_q, pending_d;
   logic [N_DIG-1:0]     an_q, an_d;
   logic [3:0]           bcd_q, bcd_d;
   logic                 fs_q, fs_d;

   logic                 tick, commit, blank;
   logic [3:0]           cur_digit;
   logic [N_DIG-1:0]     upper_zero;

   assign tick   = (cnt_q == CNT_LAST);
   assign commit = tick && (idx_q == IDX_LAST);

   // upper_zero[i] is set when digit i and every digit above it are zero.
   always_comb begin
      upper_zero = '0;
      upper_zero[N_DIG-1] = (active_q[4*(N_DIG-1) +: 4] == 4'h0);
      for (int i = N_DIG - 2; i >= 0; i--) begin
         upper_zero[i] = upper_zero[i+1] && (active_q[4*i +: 4] == 4'h0);
      end
   end

   always_comb begin
      cur_digit = 4'h0;
      for (int i = 0; i < N_DIG; i++) begin
         if (IW'(i) == idx_q) cur_digit = active_q[4*i +: 4];
      end
   end

   // Digit 0 is exempt from leading-zero blanking so a zero value still shows "0".
   assign blank = !digit_en[idx_q] ||
                  (lzb_en && (idx_q != '0) && upper_zero[idx_q]);

   always_comb begin
      cnt_d      = tick ? '0 : cnt_q + 1'b1;
      idx_d      = idx_q;
      if (commit)    idx_d = '0;
      else if (tick) idx_d = idx_q + 1'b1;

      active_d   = active_q;
      pending_d  = pending_q;
      pend_buf_d = load ? digits_in : pend_buf_q;
      if (commit) begin
         pending_d = 1'b0;
         if (load)           active_d = digits_in;
         else if (pending_q) active_d = pend_buf_q;
      end else if (load) begin
         pending_d = 1'b1;
      end

      an_d  = blank ? '1 : ~(N_DIG'(1) << idx_q);
      bcd_d = blank ? 4'hF : cur_digit;
      fs_d  = commit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         idx_q      <= '0;
         active_q   <= '0;
         pend_buf_q <= '0;
         pending_q  <= 1'b0;
         an_q       <= '1;
         bcd_q      <= 4'hF;
         fs_q       <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         active_q   <= active_d;
         pend_buf_q <= pend_buf_d;
         pending_q  <= pending_d;
         an_q       <= an_d;
         bcd_q      <= bcd_d;
         fs_q       <= fs_d;
      end
   end

   assign AN          = an_q;
   assign bcd         = bcd_q;
   assign pending     = pending_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl: directed scenarios plus random loads, checked each
// cycle against a time-indexed reference model of the scan.
module tb_ssd_scan_ctrl;
   localparam int N   = 8;
   localparam int DIV = 4;
   localparam int FRAME = N * DIV;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [31:0]   digits_in;
   logic          load;
   logic [7:0]    digit_en;
   logic          lzb_en;
   logic [3:0]    bcd;
   logic [7:0]    AN;
   logic          pending;
   logic          frame_start;

   ssd_scan_ctrl #(.N_DIG(N), .REFRESH_DIV(DIV)) dut (
      .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .load(load),
      .digit_en(digit_en), .lzb_en(lzb_en), .bcd(bcd), .AN(AN),
      .pending(pending), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // model state: k = rising edges since reset release
   int          k;
   logic [31:0] m_active, m_buf;
   logic        m_pend;
   logic [7:0]  e_an;
   logic [3:0]  e_bcd;
   logic        e_pend, e_fs;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (k=%0d t=%0t)", tag, got, exp, k, $time);
      end
   endtask

   task automatic model_reset();
      k = 0; m_active = '0; m_buf = '0; m_pend = 1'b0;
   endtask

   task automatic model_edge();
      int  pos;
      bit  blk, cmt;
      k++;
      pos = ((k - 1) / DIV) % N;
      blk = !digit_en[pos] || (lzb_en && pos != 0 && (m_active >> (4 * pos)) == 0);
      e_an  = blk ? 8'hFF : ~(8'h01 << pos);
      e_bcd = blk ? 4'hF : 4'((m_active >> (4 * pos)) & 32'hF);
      cmt = (k % FRAME) == 0;
      if (cmt) begin
         if (load)        m_active = digits_in;
         else if (m_pend) m_active = m_buf;
         m_pend = 1'b0;
      end else if (load) begin
         m_pend = 1'b1;
      end
      if (load) m_buf = digits_in;
      e_pend = m_pend;
      e_fs   = cmt;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("an", 32'(AN), 32'(e_an));
      check("bcd", 32'(bcd), 32'(e_bcd));
      check("pending", 32'(pending), 32'(e_pend));
      check("frame_start", 32'(frame_start), 32'(e_fs));
      check("an_onehot", 32'($countones(~AN) <= 1), 32'd1);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic load_one(input logic [31:0] v);
      digits_in = v; load = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_an"}, 32'(AN), 32'hFF);
      check({tag, "_bcd"}, 32'(bcd), 32'hF);
      check({tag, "_pending"}, 32'(pending), 32'd0);
      check({tag, "_fs"}, 32'(frame_start), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; digits_in = '0; load = 1'b0; digit_en = 8'hFF; lzb_en = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_vals("rst");
      rst_n = 1'b1;

      // plain scan of the all-zero frame
      run(70);

      // mid-frame load shows on the following frame
      run(10);
      load_one(32'h8765_4321);
      run(60);

      // double load in one frame: last wins
      load_one(32'h1111_1111);
      run(3);
      load_one(32'h2222_2222);
      run(FRAME);

      // load coincident with commit bypasses the pending buffer
      load_one(32'h5555_5555);
      while (((k + 1) % FRAME) != 0) step();
      load_one(32'h9A0C_DE34);
      run(40);

      // leading-zero blanking
      lzb_en = 1'b1;
      load_one(32'h0000_0305);
      run(70);
      load_one(32'h0000_0000);
      run(70);
      lzb_en = 1'b0;

      // per-digit enable with a pass-through code
      digit_en = 8'h0F;
      load_one(32'h1234_00B0);
      run(70);
      digit_en = 8'hFF;

      // asynchronous reset mid-frame with data pending
      run(5);
      load_one(32'h4444_4444);
      run(3);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("async_rst");
      repeat (2) @(negedge clk);
      check_reset_vals("hold_rst");
      model_reset();
      rst_n = 1'b1;
      run(70);

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         int nz;
         logic [31:0] mask;
         nz = $urandom_range(0, 8);
         mask = (nz == 8) ? 32'hFFFF_FFFF : ((32'h1 << (4 * nz)) - 1);
         digits_in = $urandom() & mask;
         load = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 49) == 0) digit_en = 8'($urandom());
         if ($urandom_range(0, 49) == 0) lzb_en = 1'($urandom());
         step();
      end
      load = 1'b0;
      run(FRAME);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
